i3c_xfer_sequencer: RTL and testbench
=====================================

// Module: i3c_xfer_sequencer
// PURPOSE
//  Turns high-level transfer commands (addr, RnW, length, stop) plus a TX byte stream into
//  format-FIFO entries for i2c_controller_fsm. It sits between the HCI command/data queues and the controller.
//  Splits reads into <=256-byte chunks, tracks in-flight entries, collects RX bytes, and posts one response per command.
// PARAMETERS
//  LenWidth        12  width of cmd_len_i / resp_len_o (max transfer 2^LenWidth-1 bytes)
//  MaxOutstanding   8  max fmt entries issued but not yet completed (cmd_complete_i); >=2
// PORTS
//  clk_i            in   1         clock
//  rst_i            in   1         asynchronous, active-high reset
//  cmd_valid_i      in   1         command valid
//  cmd_ready_o      out  1         command accepted when valid&ready
//  cmd_addr_i       in   7         target static/dynamic address
//  cmd_rnw_i        in   1         1=read, 0=write
//  cmd_len_i        in   LenWidth  data bytes (0 = address-only)
//  cmd_stop_i       in   1         1=STOP at end, 0=leave bus for Sr
//  abort_i          in   1         level; abort current command
//  tx_valid_i/tx_ready_o/tx_data_i[7:0]   write-data stream (valid/ready)
//  fmt_valid_o      out  1         -> fmt_fifo_rvalid_i
//  fmt_ready_i      in   1         <- fmt_fifo_rready_o (entry consumed)
//  fmt_byte_o       out  8         entry byte
//  fmt_start_o, fmt_stop_o, fmt_readb_o, fmt_rcont_o, fmt_nakok_o  out 1 each  entry flags
//  cmd_complete_i   in   1         pulse per fmt entry finished on bus
//  nak_i            in   1         pulse: unexpected NAK
//  host_idle_i      in   1         controller idle
//  unhandled_nak_o  out  1         -> unhandled_unexp_nak_i
//  rx_valid_i/rx_data_i[7:0]  in   byte from controller
//  rx_valid_o/rx_data_o[7:0]  out  registered RX passthrough (1-cycle latency)
//  resp_valid_o/resp_ready_i       response handshake
//  resp_status_o    out  2         0=OK 1=NAK 2=ABORT
//  resp_len_o       out  LenWidth  data bytes transferred
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cmd_ready_o=1; counters 0.
//  States: IDLE->ADDR->{WDATA|RCHUNK}->WAIT->RESP->IDLE; DRAIN on NAK/abort.
//  IDLE: cmd_ready_o=1; on accept, latch cmd and go to ADDR; fmt_valid_o goes high the next cycle.
//  ADDR: byte={addr,rnw}, start=1, stop=cmd_stop&(len==0). Accept -> WDATA (write,len>0), RCHUNK (read,len>0), else WAIT.
//  WDATA: fmt_valid_o=tx_valid_i, tx_ready_o=fmt_ready_i, byte=tx_data_i, stop=cmd_stop on last byte.
//   The byte counter increments per accept; after the last byte go to WAIT.
//  RCHUNK: chunk=min(rem,256), byte=chunk[7:0] (256 encodes 0x00), readb=1, rcont=(rem>256), stop=cmd_stop&(rem<=256).
//   rem -= chunk on accept; go to WAIT when rem==0.
//  fmt_nakok_o always 0. fmt_valid_o is forced 0 while outstanding==MaxOutstanding.
//  outstanding: +1 on fmt accept, -1 on cmd_complete_i; both in one cycle = unchanged; never wraps.
//  RX: in a read cmd, rx_valid_i -> rx_valid_o/rx_data_o next cycle, rx_cnt++.
//   RX bytes beyond len, or outside a read, are dropped (rx_valid_o stays 0).
//  WAIT: exit to RESP(OK) when outstanding==0 and (write | rx_cnt==len).
//  nak_i in ADDR/WDATA/RCHUNK/WAIT: status=NAK, stop issuing fmt, go to DRAIN.
//   nak_i and abort_i in the same cycle: NAK wins.
//  abort_i in any non-IDLE/RESP state: status=ABORT, go to DRAIN.
//  DRAIN: tx_ready_o=1 until the remaining write bytes of the cmd are consumed (tx stream stays aligned).
//   Then wait for host_idle_i and clear outstanding -> RESP.
//  RESP: resp_valid_o=1 held stable until resp_ready_i; resp_len = write bytes accepted by fmt, or rx_cnt for reads.
//   unhandled_nak_o=1 while in RESP with status NAK. Handshake -> IDLE.
//  rst_i mid-command: immediate return to IDLE, the command is dropped, no response.
// TESTING
//  1 Write addr 0x50, len 3, stop=1, tx AA BB CC -> fmt entries: A0(start), AA, BB, CC(stop); 4 completions -> resp OK, len 3.
//  2 Read 0x21, len 300, stop=1 -> 43(start), 00(readb,rcont), 2C(readb,stop); 300 rx -> resp OK, len 300.
//  3 Write len 4, nak_i after address -> 4 tx bytes drained, resp NAK len 0, unhandled_nak_o=1 until resp_ready_i.
//  4 Write len 10 with cmd_complete_i withheld -> fmt_valid_o drops after 8 entries; resumes after 1 completion.
//  5 abort_i during RCHUNK, host_idle_i after 5 cycles -> resp ABORT; nak_i+abort_i same cycle -> NAK.
//  6 rst_i during WDATA -> next cycle state IDLE, cmd_ready_o=1, fmt_valid_o=0, resp_valid_o=0.

Source files
------------

// File: rtl/i3c_xfer_sequencer.sv
// i3c_xfer_sequencer: converts HCI transfer commands and a TX byte stream into format-FIFO
// entries for the I2C/I3C controller, tracks in-flight entries and posts one response per command.
module i3c_xfer_sequencer #(
  parameter int unsigned LenWidth       = 12,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [6:0]          cmd_addr_i,
  input  logic                cmd_rnw_i,
  input  logic [LenWidth-1:0] cmd_len_i,
  input  logic                cmd_stop_i,
  input  logic                abort_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  input  logic [7:0]          tx_data_i,
  output logic                fmt_valid_o,
  input  logic                fmt_ready_i,
  output logic [7:0]          fmt_byte_o,
  output logic                fmt_start_o,
  output logic                fmt_stop_o,
  output logic                fmt_readb_o,
  output logic                fmt_rcont_o,
  output logic                fmt_nakok_o,
  input  logic                cmd_complete_i,
  input  logic                nak_i,
  input  logic                host_idle_i,
  output logic                unhandled_nak_o,
  input  logic                rx_valid_i,
  input  logic [7:0]          rx_data_i,
  output logic                rx_valid_o,
  output logic [7:0]          rx_data_o,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [1:0]          resp_status_o,
  output logic [LenWidth-1:0] resp_len_o
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam logic [OutW-1:0]     OutMax   = OutW'(MaxOutstanding);
  localparam logic [LenWidth-1:0] ChunkMax = LenWidth'(256);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_WDATA  = 3'd2;
  localparam logic [2:0] S_RCHUNK = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_NAK   = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  logic [2:0]          state_q, state_d;
  logic [6:0]          addr_q, addr_d;
  logic                rnw_q, rnw_d;
  logic                stop_q, stop_d;
  logic [LenWidth-1:0] len_q, len_d;
  logic [LenWidth-1:0] wcnt_q, wcnt_d;
  logic [LenWidth-1:0] txcnt_q, txcnt_d;
  logic [LenWidth-1:0] rem_q, rem_d;
  logic [LenWidth-1:0] rxcnt_q, rxcnt_d;
  logic [OutW-1:0]     out_q, out_d;
  logic [1:0]          status_q, status_d;
  logic                rx_valid_q;
  logic [7:0]          rx_data_q;

  logic                fmt_base_valid;
  logic                fmt_acc;
  logic                out_full;
  logic                out_clr;
  logic                rx_window;
  logic                rx_take;
  logic                wlast;
  logic                rmore;
  logic [LenWidth-1:0] chunk;

  assign out_full  = (out_q == OutMax);
  assign wlast     = (wcnt_q == len_q - LenWidth'(1));
  assign rmore     = (rem_q > ChunkMax);
  assign chunk     = rmore ? ChunkMax : rem_q;
  assign rx_window = rnw_q && (state_q inside {S_ADDR, S_RCHUNK, S_WAIT, S_DRAIN});
  assign rx_take   = rx_valid_i && rx_window && (rxcnt_q != len_q);

  assign cmd_ready_o     = (state_q == S_IDLE);
  assign resp_valid_o    = (state_q == S_RESP);
  assign resp_status_o   = status_q;
  assign resp_len_o      = rnw_q ? rxcnt_q : wcnt_q;
  assign unhandled_nak_o = (state_q == S_RESP) && (status_q == ST_NAK);
  assign fmt_nakok_o     = 1'b0;
  assign rx_valid_o      = rx_valid_q;
  assign rx_data_o       = rx_data_q;

  // Next-state, entry generation and counter bookkeeping.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    rnw_d          = rnw_q;
    stop_d         = stop_q;
    len_d          = len_q;
    wcnt_d         = wcnt_q;
    txcnt_d        = txcnt_q;
    rem_d          = rem_q;
    rxcnt_d        = rxcnt_q + LenWidth'(rx_take);
    status_d       = status_q;
    out_clr        = 1'b0;
    fmt_base_valid = 1'b0;
    fmt_byte_o     = 8'h00;
    fmt_start_o    = 1'b0;
    fmt_stop_o     = 1'b0;
    fmt_readb_o    = 1'b0;
    fmt_rcont_o    = 1'b0;
    tx_ready_o     = 1'b0;

    // Entries are held back while the controller already owns MaxOutstanding of them.
    case (state_q)
      S_ADDR: begin
        fmt_base_valid = 1'b1;
        fmt_byte_o     = {addr_q, rnw_q};
        fmt_start_o    = 1'b1;
        fmt_stop_o     = stop_q && (len_q == '0);
      end
      S_WDATA: begin
        fmt_base_valid = tx_valid_i;
        fmt_byte_o     = tx_data_i;
        fmt_stop_o     = stop_q && wlast;
        tx_ready_o     = fmt_ready_i && !out_full;
      end
      S_RCHUNK: begin
        fmt_base_valid = 1'b1;
        fmt_byte_o     = chunk[7:0];
        fmt_readb_o    = 1'b1;
        fmt_rcont_o    = rmore;
        fmt_stop_o     = stop_q && !rmore;
      end
      S_DRAIN: begin
        tx_ready_o = !rnw_q && (txcnt_q != len_q);
      end
      default: ;
    endcase

    fmt_valid_o = fmt_base_valid && !out_full;
    fmt_acc     = fmt_valid_o && fmt_ready_i;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d   = cmd_addr_i;
          rnw_d    = cmd_rnw_i;
          stop_d   = cmd_stop_i;
          len_d    = cmd_len_i;
          rem_d    = cmd_len_i;
          wcnt_d   = '0;
          txcnt_d  = '0;
          rxcnt_d  = '0;
          status_d = ST_OK;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (fmt_acc) begin
          if (len_q == '0)  state_d = S_WAIT;
          else if (rnw_q)   state_d = S_RCHUNK;
          else              state_d = S_WDATA;
        end
      end
      S_WDATA: begin
        if (fmt_acc) begin
          wcnt_d  = wcnt_q + LenWidth'(1);
          txcnt_d = txcnt_q + LenWidth'(1);
          if (wlast) state_d = S_WAIT;
        end
      end
      S_RCHUNK: begin
        if (fmt_acc) begin
          rem_d = rem_q - chunk;
          if (!rmore) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if ((out_q == '0) && (!rnw_q || (rxcnt_q == len_q))) state_d = S_RESP;
      end
      S_DRAIN: begin
        // Swallow the rest of the command's TX bytes so the next command starts aligned.
        if (tx_ready_o && tx_valid_i) txcnt_d = txcnt_q + LenWidth'(1);
        if ((rnw_q || (txcnt_q == len_q)) && host_idle_i) begin
          out_clr = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q inside {S_ADDR, S_WDATA, S_RCHUNK, S_WAIT}) begin
      if (nak_i) begin
        status_d = ST_NAK;
        state_d  = S_DRAIN;
      end else if (abort_i) begin
        status_d = ST_ABORT;
        state_d  = S_DRAIN;
      end
    end

    out_d = out_q;
    if (out_clr) begin
      out_d = '0;
    end else if (fmt_acc && !(cmd_complete_i && (out_q != '0))) begin
      out_d = out_q + OutW'(1);
    end else if (!fmt_acc && cmd_complete_i && (out_q != '0)) begin
      out_d = out_q - OutW'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rnw_q      <= 1'b0;
      stop_q     <= 1'b0;
      len_q      <= '0;
      wcnt_q     <= '0;
      txcnt_q    <= '0;
      rem_q      <= '0;
      rxcnt_q    <= '0;
      out_q      <= '0;
      status_q   <= ST_OK;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rnw_q      <= rnw_d;
      stop_q     <= stop_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      txcnt_q    <= txcnt_d;
      rem_q      <= rem_d;
      rxcnt_q    <= rxcnt_d;
      out_q      <= out_d;
      status_q   <= status_d;
      rx_valid_q <= rx_take;
      if (rx_take) rx_data_q <= rx_data_i;
    end
  end

endmodule

// File: tb/tb_i3c_xfer_sequencer.sv
// Scoreboard bench for i3c_xfer_sequencer: expected fmt entries, responses and RX bytes are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_i3c_xfer_sequencer;

  localparam int unsigned LenWidth = 12;

  typedef struct packed {
    logic [7:0] b;
    logic       start;
    logic       stop;
    logic       readb;
    logic       rcont;
    logic       nakok;
  } fmt_t;

  typedef struct packed {
    logic [1:0]          st;
    logic [LenWidth-1:0] len;
  } resp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic cmd_valid_i, cmd_ready_o, cmd_rnw_i, cmd_stop_i, abort_i;
  logic [6:0] cmd_addr_i;
  logic [LenWidth-1:0] cmd_len_i;
  logic tx_valid_i, tx_ready_o;
  logic [7:0] tx_data_i;
  logic fmt_valid_o, fmt_ready_i, fmt_start_o, fmt_stop_o, fmt_readb_o, fmt_rcont_o, fmt_nakok_o;
  logic [7:0] fmt_byte_o;
  logic cmd_complete_i, nak_i, host_idle_i, unhandled_nak_o;
  logic rx_valid_i, rx_valid_o;
  logic [7:0] rx_data_i, rx_data_o;
  logic resp_valid_o, resp_ready_i;
  logic [1:0] resp_status_o;
  logic [LenWidth-1:0] resp_len_o;

  i3c_xfer_sequencer #(.LenWidth(LenWidth), .MaxOutstanding(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_rnw_i(cmd_rnw_i), .cmd_len_i(cmd_len_i), .cmd_stop_i(cmd_stop_i), .abort_i(abort_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
    .fmt_valid_o(fmt_valid_o), .fmt_ready_i(fmt_ready_i), .fmt_byte_o(fmt_byte_o),
    .fmt_start_o(fmt_start_o), .fmt_stop_o(fmt_stop_o), .fmt_readb_o(fmt_readb_o),
    .fmt_rcont_o(fmt_rcont_o), .fmt_nakok_o(fmt_nakok_o),
    .cmd_complete_i(cmd_complete_i), .nak_i(nak_i), .host_idle_i(host_idle_i),
    .unhandled_nak_o(unhandled_nak_o),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_status_o(resp_status_o), .resp_len_o(resp_len_o)
  );

  always #5 clk_i = ~clk_i;

  fmt_t       fmt_q[$];
  resp_t      resp_q[$];
  logic [7:0] rx_q[$];
  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  int cpl_cnt = 0;
  logic auto_cpl = 1'b1;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_fmt(logic [7:0] b, logic s, logic p, logic r, logic c);
    fmt_t e;
    e = '{b: b, start: s, stop: p, readb: r, rcont: c, nakok: 1'b0};
    fmt_q.push_back(e);
  endtask

  task automatic push_resp(logic [1:0] st, int len);
    resp_t r;
    r = '{st: st, len: LenWidth'(len)};
    resp_q.push_back(r);
  endtask

  // Monitor: compares every fmt accept, response handshake and RX output against the queues.
  always @(negedge clk_i) begin : mon
    fmt_t  fa;
    resp_t ra;
    if (!rst_i) begin
      if (fmt_valid_o && fmt_ready_i) begin
        acc_cnt++;
        fa = '{b: fmt_byte_o, start: fmt_start_o, stop: fmt_stop_o, readb: fmt_readb_o,
               rcont: fmt_rcont_o, nakok: fmt_nakok_o};
        if (fmt_q.size() == 0) check("fmt_unexpected", int'(fa), -1);
        else check("fmt_entry", int'(fa), int'(fmt_q.pop_front()));
      end
      if (resp_valid_o && resp_ready_i) begin
        ra = '{st: resp_status_o, len: resp_len_o};
        if (resp_q.size() == 0) check("resp_unexpected", int'(ra), -1);
        else check("resp", int'(ra), int'(resp_q.pop_front()));
      end
      if (rx_valid_o) begin
        if (rx_q.size() == 0) check("rx_unexpected", int'(rx_data_o), -1);
        else check("rx_data", int'(rx_data_o), int'(rx_q.pop_front()));
      end
    end
  end

  // Controller model: one completion per accepted entry while enabled.
  always @(posedge clk_i) begin
    #1;
    if (auto_cpl && (acc_cnt > cpl_cnt)) begin
      cmd_complete_i = 1'b1;
      cpl_cnt++;
    end else begin
      cmd_complete_i = 1'b0;
    end
  end

  task automatic issue_cmd(logic [6:0] a, logic rnw, int len, logic stop);
    bit done = 0;
    cmd_addr_i = a; cmd_rnw_i = rnw; cmd_len_i = LenWidth'(len); cmd_stop_i = stop;
    cmd_valid_i = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk_i);
      if (cmd_ready_o) done = 1;
      @(posedge clk_i); #1;
    end
    cmd_valid_i = 1'b0;
    if (!done) check("cmd_timeout", 0, 1);
  endtask

  task automatic send_tx(int n, int first, int step);
    for (int i = 0; i < n; i++) begin
      bit done = 0;
      tx_valid_i = 1'b1;
      tx_data_i  = 8'(first + i * step);
      for (int k = 0; k < 2000 && !done; k++) begin
        @(negedge clk_i);
        if (tx_ready_o) done = 1;
        @(posedge clk_i); #1;
      end
      if (!done) begin
        tx_valid_i = 1'b0;
        check("tx_timeout", 0, 1);
        return;
      end
    end
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_fmt_empty(string name);
    bit ok = 0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(posedge clk_i);
      if (fmt_q.size() == 0) ok = 1;
    end
    #1;
    if (!ok) check(name, 0, 1);
  endtask

  task automatic wait_done(string name);
    bit ok = 0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(posedge clk_i); #1;
      if (fmt_q.size() == 0 && resp_q.size() == 0 && rx_q.size() == 0 &&
          acc_cnt == cpl_cnt && !resp_valid_o) ok = 1;
    end
    check(name, int'(ok), 1);
  endtask

  initial begin
    int base;
    bit ok;
    rst_i = 1'b1;
    cmd_valid_i = 0; cmd_addr_i = '0; cmd_rnw_i = 0; cmd_len_i = '0; cmd_stop_i = 0;
    abort_i = 0; tx_valid_i = 0; tx_data_i = '0; fmt_ready_i = 1; nak_i = 0;
    host_idle_i = 1; rx_valid_i = 0; rx_data_i = '0; resp_ready_i = 1; cmd_complete_i = 0;
    repeat (2) @(negedge clk_i);
    check("rst_cmd_ready", int'(cmd_ready_o), 1);
    check("rst_fmt_valid", int'(fmt_valid_o), 0);
    check("rst_resp_valid", int'(resp_valid_o), 0);
    check("rst_tx_ready", int'(tx_ready_o), 0);
    check("rst_rx_valid", int'(rx_valid_o), 0);
    check("rst_unhandled", int'(unhandled_nak_o), 0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    // 1: write 0x50, 3 bytes with STOP
    push_fmt(8'hA0, 1, 0, 0, 0);
    push_fmt(8'hAA, 0, 0, 0, 0);
    push_fmt(8'hBB, 0, 0, 0, 0);
    push_fmt(8'hCC, 0, 1, 0, 0);
    push_resp(2'd0, 3);
    issue_cmd(7'h50, 1'b0, 3, 1'b1);
    send_tx(3, 8'hAA, 8'h11);
    wait_done("t1_done");

    // 2: read 0x21, 300 bytes, split 256 + 44, one surplus RX byte dropped
    push_fmt(8'h43, 1, 0, 0, 0);
    push_fmt(8'h00, 0, 0, 1, 1);
    push_fmt(8'h2C, 0, 1, 1, 0);
    push_resp(2'd0, 300);
    issue_cmd(7'h21, 1'b1, 300, 1'b1);
    for (int i = 0; i < 301; i++) begin
      rx_valid_i = 1'b1;
      rx_data_i  = 8'(i);
      if (i < 300) rx_q.push_back(8'(i));
      @(posedge clk_i); #1;
    end
    rx_valid_i = 1'b0;
    wait_done("t2_done");

    // 3: NAK after the address, TX bytes drained, NAK held until response taken
    resp_ready_i = 1'b0;
    push_fmt(8'h60, 1, 0, 0, 0);
    push_resp(2'd1, 0);
    issue_cmd(7'h30, 1'b0, 4, 1'b1);
    wait_fmt_empty("t3_addr_timeout");
    nak_i = 1'b1;
    @(posedge clk_i); #1 nak_i = 1'b0;
    send_tx(4, 8'h10, 1);
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk_i);
      if (resp_valid_o) ok = 1;
    end
    check("t3_resp_seen", int'(ok), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("t3_unhandled_nak", int'(unhandled_nak_o), 1);
      check("t3_resp_held", int'(resp_valid_o), 1);
    end
    @(posedge clk_i); #1 resp_ready_i = 1'b1;
    wait_done("t3_done");
    check("t3_unhandled_clear", int'(unhandled_nak_o), 0);

    // 4: write 10 bytes with completions withheld -> stalls at 8 outstanding
    auto_cpl = 1'b0;
    push_fmt(8'h24, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) push_fmt(8'(8'h40 + i), 0, (i == 9), 0, 0);
    push_resp(2'd0, 10);
    base = acc_cnt;
    issue_cmd(7'h12, 1'b0, 10, 1'b1);
    fork
      send_tx(10, 8'h40, 1);
    join_none
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk_i);
      if (acc_cnt - base == 8) ok = 1;
    end
    check("t4_reach_8", int'(ok), 1);
    repeat (3) @(negedge clk_i);
    check("t4_stall_valid", int'(fmt_valid_o), 0);
    check("t4_stall_tx_ready", int'(tx_ready_o), 0);
    check("t4_stall_count", acc_cnt - base, 8);
    auto_cpl = 1'b1;
    @(posedge clk_i); #2 auto_cpl = 1'b0;
    repeat (6) @(negedge clk_i);
    check("t4_resume_one", acc_cnt - base, 9);
    auto_cpl = 1'b1;
    wait_done("t4_done");

    // 5a: abort during RCHUNK, host idle only after 5 cycles
    push_fmt(8'h43, 1, 0, 0, 0);
    push_resp(2'd2, 0);
    issue_cmd(7'h21, 1'b1, 300, 1'b1);
    wait_fmt_empty("t5a_addr_timeout");
    fmt_ready_i = 1'b0;
    host_idle_i = 1'b0;
    abort_i = 1'b1;
    @(posedge clk_i); #1 abort_i = 1'b0;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("t5a_wait_idle", int'(resp_valid_o), 0);
    @(posedge clk_i); #1;
    host_idle_i = 1'b1;
    fmt_ready_i = 1'b1;
    wait_done("t5a_done");

    // 5b: NAK and abort in the same cycle -> NAK
    push_fmt(8'h66, 1, 0, 0, 0);
    push_resp(2'd1, 0);
    issue_cmd(7'h33, 1'b0, 2, 1'b1);
    wait_fmt_empty("t5b_addr_timeout");
    nak_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    nak_i = 1'b0;
    abort_i = 1'b0;
    send_tx(2, 8'h70, 1);
    wait_done("t5b_done");

    // 6: reset in the middle of a write drops the command
    push_fmt(8'h88, 1, 0, 0, 0);
    push_fmt(8'h01, 0, 0, 0, 0);
    push_fmt(8'h02, 0, 0, 0, 0);
    issue_cmd(7'h44, 1'b0, 4, 1'b1);
    send_tx(2, 8'h01, 1);
    wait_fmt_empty("t6_data_timeout");
    rst_i = 1'b1;
    @(negedge clk_i);
    check("t6_cmd_ready", int'(cmd_ready_o), 1);
    check("t6_fmt_valid", int'(fmt_valid_o), 0);
    check("t6_resp_valid", int'(resp_valid_o), 0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check("t6_idle_after", int'(cmd_ready_o), 1);
    check("t6_no_resp", int'(resp_valid_o), 0);
    check("leftover_expect", fmt_q.size() + resp_q.size() + rx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
